// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Produces quotient and remainder of a WIDTH-bit dividend A over divisor B.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   -> two's-complement signed division (truncating quotient,
//                remainder takes the sign of the dividend)
//   undefined -> unsigned division
// Divide by zero (either build): quotient all ones, remainder = A, div_zero = 1.
//
// Handshake: start is sampled only while the FSM is IDLE; A and B are
// captured on that same edge. busy is high while quotient bits are being
// computed (CALC). done is a one-cycle pulse, never coincident with busy,
// marking the cycle in which quotient/remainder/div_zero are freshly valid.
// A start raised during the done cycle is sampled on the following edge.
// start while not IDLE is ignored and the operands are not re-sampled.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;        // partial remainder
    logic [WIDTH-1:0] q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] b_mag;    // divisor magnitude
    logic [WIDTH-1:0] a_raw;    // original dividend, returned on divide by zero
    logic [CW-1:0]    cnt;      // quotient bits still to produce
    logic             neg_q;    // quotient must be negated in FIX
    logic             neg_r;    // remainder must be negated in FIX
    logic             dz;       // divisor was zero

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign state_dbg = state;

    // Operand sign extraction and magnitude for the incoming operands
    always_comb begin
        a_neg_c = 1'b0;
        b_neg_c = 1'b0;
        a_mag_c = A;
        b_mag_c = B;
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_neg_c = A[WIDTH-1];
        b_neg_c = B[WIDTH-1];
        if (a_neg_c) a_mag_c = -A;
        if (b_neg_c) b_mag_c = -B;
`endif
    end

    // One restoring step: shift {R,Q} left and trial-subtract at WIDTH+1 bits
    always_comb begin
        r_sh = {r, q[WIDTH-1]};
        t    = r_sh - {1'b0, b_mag};
    end

    // Sign correction applied to the magnitude results (flags are 0 unsigned)
    always_comb begin
        q_fix = neg_q ? -q : q;
        r_fix = neg_r ? -r : r;
    end

    // Divider FSM with registered handshake and result outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            r         <= '0;
            q         <= '0;
            b_mag     <= '0;
            a_raw     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_raw <= A;
                        b_mag <= b_mag_c;
                        neg_q <= a_neg_c ^ b_neg_c;
                        neg_r <= a_neg_c;
                        r     <= '0;
                        q     <= a_mag_c;
                        cnt   <= CW'(WIDTH);
                        if (B == '0) begin
                            dz    <= 1'b1;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!t[WIDTH]) begin
                        r <= t[WIDTH-1:0];
                    end else begin
                        r <= r_sh[WIDTH-1:0];
                    end
                    q   <= {q[WIDTH-2:0], ~t[WIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= a_raw;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        div_zero  <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed bench for seq_divider with hand-computed results.
// Builds with or without SEQ_DIVIDER_SIGNED_EN; sign-dependent vectors
// follow the macro.
module tb_seq_divider;

    localparam int W = 32;

    logic         clock;
    logic         clear;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic [1:0]   state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // comparison point
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // wait for done with a bound; returns edges seen and busy-high cycles
    task automatic wait_done(output int lat, inout int bcnt, output int both);
        lat  = 0;
        both = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bcnt++;
            if (busy && done) both++;
        end
    endtask

    // scoreboard check of a completed result against the expected queue
    task automatic score(input string tag, input logic exp_dz);
        logic [W-1:0] eq, er;
        if (exp_q.size() < 2) begin
            chk({tag, " queue"}, W'(exp_q.size()), 32'd2);
        end else begin
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            chk({tag, " quotient"}, quotient, eq);
            chk({tag, " remainder"}, remainder, er);
            chk({tag, " div_zero"}, W'(div_zero), W'(exp_dz));
        end
    endtask

    // driver: one divide, start pulsed for one cycle, full result check
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int exp_lat, input int exp_busy);
        int lat, bcnt, both;
        exp_q.push_back(eq);
        exp_q.push_back(er);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        wait_done(lat, bcnt, both);
        chk({tag, " latency"}, W'(lat), W'(exp_lat));
        if (exp_busy >= 0) chk({tag, " busy cycles"}, W'(bcnt), W'(exp_busy));
        chk({tag, " busy&done"}, W'(both), 32'd0);
        score(tag, edz);
    endtask

    initial begin
        int lat, bcnt, both, ndone;
        clear = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #12;
        chk("reset busy", W'(busy), 32'd0);
        chk("reset done", W'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_zero", W'(div_zero), 32'd0);
        chk("reset state", W'(state_dbg), 32'd0);
        @(posedge clock); #1;
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // basic divide, then results hold and done is a single pulse
        do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32);
        @(posedge clock); #1;
        chk("done one cycle", W'(done), 32'd0);
        repeat ($urandom_range(2, 5)) @(posedge clock);
        #1;
        chk("hold quotient", quotient, 32'd14);
        chk("hold remainder", remainder, 32'd2);

        do_div("7/100", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 33, 32);
        do_div("x/1", 32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 32'd0, 1'b0, 33, 32);

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_div("-100/7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, 32);
        do_div("-1/16", 32'hFFFFFFFF, 32'd16, 32'd0, 32'hFFFFFFFF, 1'b0, 33, 32);
        do_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, 32);
`else
        do_div("fffffffe/2", 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 32'd0, 1'b0, 33, 32);
        do_div("ffffffff/16", 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32'd15, 1'b0, 33, 32);
        do_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, 32);
`endif

        // divide by zero, then a normal divide clears div_zero
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
        do_div("div0", 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, -1);
        do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 32);

        // start while busy is ignored
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd2);
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        A = 32'd50;
        B = 32'd5;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        bcnt = 0;
        wait_done(lat, bcnt, both);
        chk("ignore latency", W'(lat + 10), 32'd33);
        score("ignore", 1'b0);

        // back-to-back start in the done cycle
        do_div("50/5 b2b", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 32);

        // asynchronous clear mid-divide
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        clear = 1'b0;
        #1;
        chk("clr busy", W'(busy), 32'd0);
        chk("clr done", W'(done), 32'd0);
        chk("clr quotient", quotient, 32'd0);
        chk("clr remainder", remainder, 32'd0);
        chk("clr div_zero", W'(div_zero), 32'd0);
        chk("clr state", W'(state_dbg), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        chk("clr no done", W'(ndone), 32'd0);
        do_div("after clr", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // overall time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
